// File: rtl/led_pattern_engine_pkg.sv
// Shared constants for the LED pattern engine: pattern codes and the sparkle LFSR.
// The LFSR is a 16-bit Fibonacci register with taps 15,13,12,10 (maximal length).
package led_pkg;

  localparam logic [2:0] PAT_KNIGHT  = 3'd0;
  localparam logic [2:0] PAT_WALK    = 3'd1;
  localparam logic [2:0] PAT_EXPAND  = 3'd2;
  localparam logic [2:0] PAT_BLINK   = 3'd3;
  localparam logic [2:0] PAT_ALT     = 3'd4;
  localparam logic [2:0] PAT_MARQUEE = 3'd5;
  localparam logic [2:0] PAT_SPARKLE = 3'd6;
  localparam logic [2:0] PAT_OFF     = 3'd7;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    lfsr_next = {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/led_pattern_engine_prescaler.sv
// Clock-enable prescaler: one step_en pulse every BASE_DIV<<speed_sel cycles,
// or a manual step pulse while paused.
module led_step_prescaler #(
  parameter int BASE_DIV = 2,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       pause,
  input  logic       step,
  input  logic [1:0] speed_sel,
  output logic       step_en
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             hit;

  // Comparing with >= means a speed change mid-count never has to wrap a stale count.
  assign limit = CNT_W'((BASE_DIV << speed_sel) - 1);
  assign hit   = (cnt >= limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena && !pause) begin
      cnt <= hit ? '0 : cnt + 1'b1;
    end
  end

  assign step_en = ena && (pause ? step : hit);

endmodule

// File: rtl/led_pattern_engine.sv
// Parametrised LED pattern engine: eight patterns stepped by a clock-enable prescaler,
// with pattern switches taken only on a step so no frame mixes two patterns.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int LED_W    = 8,
  parameter int BASE_DIV = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       pat_sel,
  input  logic [1:0]       speed_sel,
  input  logic             pause,
  input  logic             step,
  output logic [LED_W-1:0] led_out,
  output logic             frame_tick
);

  localparam int H    = LED_W / 2;
  localparam int PH_W = $clog2(2 * LED_W);

  localparam logic [LED_W-1:0]   ONE       = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0]   WALK_BASE = {{(LED_W-2){1'b0}}, 2'b11};
  localparam logic [2*LED_W-1:0] MARQ_BASE = {{(2*LED_W-3){1'b0}}, 3'b111};

  logic [2:0]       active_q, active_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             tick_q, tick_d;
  logic             step_en;

  led_step_prescaler #(
    .BASE_DIV(BASE_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .pause    (pause),
    .step     (step),
    .speed_sel(speed_sel),
    .step_en  (step_en)
  );

  // Sparkle and off never use the phase counter, so they report a period of 1.
  function automatic logic [PH_W-1:0] period_of(input logic [2:0] pat);
    case (pat)
      PAT_KNIGHT:  period_of = PH_W'(2 * H - 2);
      PAT_WALK:    period_of = PH_W'(2 * LED_W - 4);
      PAT_EXPAND:  period_of = PH_W'(2 * H);
      PAT_BLINK:   period_of = PH_W'(2);
      PAT_ALT:     period_of = PH_W'(2);
      PAT_MARQUEE: period_of = PH_W'(LED_W);
      default:     period_of = PH_W'(1);
    endcase
  endfunction

  function automatic logic [PH_W-1:0] phase_after(input logic [2:0] pat, input logic [PH_W-1:0] ph);
    logic [PH_W:0] nxt;
    nxt = {1'b0, ph} + 1'b1;
    phase_after = (nxt >= {1'b0, period_of(pat)}) ? '0 : nxt[PH_W-1:0];
  endfunction

  function automatic logic [LED_W-1:0] frame_of(input logic [2:0] pat, input logic [PH_W-1:0] ph,
                                               input logic [15:0] lf);
    logic [LED_W-1:0]   f;
    logic [2*LED_W-1:0] rot;
    int                 p;
    int                 q;
    f   = '0;
    rot = '0;
    p   = int'(ph);
    q   = 0;
    case (pat)
      PAT_KNIGHT: begin
        q = (p < H) ? p : (2 * H - 2 - p);
        f = (ONE << q) | (ONE << (LED_W - 1 - q));
      end
      PAT_WALK: begin
        q = (p < LED_W - 1) ? p : (2 * LED_W - 4 - p);
        f = WALK_BASE << q;
      end
      PAT_EXPAND: begin
        if (p != 2 * H - 1) begin
          q = (p < H) ? p : (2 * H - 2 - p);
          f = (~({LED_W{1'b1}} << (2 * q + 2))) << (H - 1 - q);
        end
      end
      PAT_BLINK:   f = (ph == '0) ? '1 : '0;
      PAT_ALT:     f = (ph == '0) ? {H{2'b10}} : {H{2'b01}};
      PAT_MARQUEE: begin
        rot = MARQ_BASE << p;
        f   = rot[LED_W-1:0] | rot[2*LED_W-1:LED_W];
      end
      PAT_SPARKLE: f = lf[LED_W-1:0];
      default:     f = '0;
    endcase
    frame_of = f;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= pat_sel;
      phase_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      led_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      lfsr_q   <= lfsr_d;
      led_q    <= led_d;
      tick_q   <= tick_d;
    end
  end

  // A new pattern starts from its own phase 0 on the very step it is taken.
  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    lfsr_d   = lfsr_q;
    led_d    = led_q;
    tick_d   = tick_q;
    if (ena) begin
      tick_d = 1'b0;
      if (step_en) begin
        if (pat_sel != active_q) begin
          active_d = pat_sel;
          led_d    = frame_of(pat_sel, '0, LFSR_SEED);
          tick_d   = 1'b1;
          phase_d  = phase_after(pat_sel, '0);
          lfsr_d   = (pat_sel == PAT_SPARKLE) ? lfsr_next(LFSR_SEED) : lfsr_q;
        end else begin
          led_d   = frame_of(active_q, phase_q, lfsr_q);
          tick_d  = (active_q == PAT_SPARKLE) ? (lfsr_q == LFSR_SEED) : (phase_q == '0);
          phase_d = phase_after(active_q, phase_q);
          if (active_q == PAT_SPARKLE) begin
            lfsr_d = lfsr_next(lfsr_q);
          end
        end
      end
    end
  end

  always_comb begin
    led_out    = led_q;
    frame_tick = tick_q;
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: an 8-LED and a 12-LED instance share stimulus,
// each step's frame and frame_tick are compared against hand-computed tables.
`timescale 1ns/1ps
module tb_led_pattern_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        pause;
  logic        step;
  logic [2:0]  pat_sel;
  logic [1:0]  speed_sel;
  logic [7:0]  led8;
  logic        tick8;
  logic [11:0] led12;
  logic        tick12;

  int          checkCount = 0;
  int          failCount  = 0;
  logic [15:0] expQ[$];
  bit          tickQ[$];
  bit          use12 = 1'b0;

  always #5 clk = ~clk;

  led_pattern_engine #(.LED_W(8), .BASE_DIV(2), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pat_sel(pat_sel), .speed_sel(speed_sel),
    .pause(pause), .step(step), .led_out(led8), .frame_tick(tick8)
  );

  led_pattern_engine #(.LED_W(12), .BASE_DIV(2), .CNT_W(16)) dut12 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pat_sel(pat_sel), .speed_sel(speed_sel),
    .pause(pause), .step(step), .led_out(led12), .frame_tick(tick12)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] p,
                               input logic [1:0] s, input logic pa, input logic st);
    rst_n     = r;
    ena       = e;
    pat_sel   = p;
    speed_sel = s;
    pause     = pa;
    step      = st;
  endtask

  task automatic clockCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] curLed();
    return use12 ? 32'(led12) : 32'(led8);
  endfunction

  function automatic logic [31:0] curTick();
    return use12 ? 32'(tick12) : 32'(tick8);
  endfunction

  // Walks expQ/tickQ one step at a time, also checking the cycle just before each step.
  task automatic stepCheck(input string tag, input int period);
    for (int i = 0; i < expQ.size(); i++) begin
      if (period > 1) begin
        clockCycles(period - 1);
        checkOutput($sformatf("%s_gap_tick%0d", tag, i), curTick(), 32'(0));
        if (i > 0) checkOutput($sformatf("%s_hold%0d", tag, i), curLed(), 32'(expQ[i-1]));
      end
      clockCycles(1);
      checkOutput($sformatf("%s_led%0d", tag, i), curLed(), 32'(expQ[i]));
      checkOutput($sformatf("%s_tick%0d", tag, i), curTick(), 32'(tickQ[i]));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0);
    clockCycles(2);
    checkOutput("rst_led", 32'(led8), 32'h0);
    checkOutput("rst_tick", 32'(tick8), 32'h0);
    rst_n = 1'b1;
    expQ  = '{16'h81, 16'h42, 16'h24, 16'h18, 16'h24, 16'h42, 16'h81};
    tickQ = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    stepCheck("knight", 2);

    pat_sel   = 3'd2;
    speed_sel = 2'd3;
    expQ  = '{16'h18, 16'h3C, 16'h7E, 16'hFF, 16'h7E, 16'h3C, 16'h18, 16'h00, 16'h18};
    tickQ = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    stepCheck("expand", 16);
    clockCycles(6);
    checkOutput("speed_hold", 32'(led8), 32'h18);
    speed_sel = 2'd0;
    clockCycles(1);
    checkOutput("speed_change", 32'(led8), 32'h3C);

    pat_sel = 3'd5;
    expQ  = '{16'h07};
    tickQ = '{1'b1};
    stepCheck("marquee", 2);
    pause = 1'b1;
    clockCycles(40);
    checkOutput("pause_led", 32'(led8), 32'h07);
    checkOutput("pause_tick", 32'(tick8), 32'h0);
    ena  = 1'b0;
    step = 1'b1;
    clockCycles(1);
    step = 1'b0;
    ena  = 1'b1;
    checkOutput("ena_over_step", 32'(led8), 32'h07);
    expQ = '{16'h0E, 16'h1C, 16'h38};
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      clockCycles(1);
      step = 1'b0;
      checkOutput($sformatf("pulse_led%0d", i), 32'(led8), 32'(expQ[i]));
      clockCycles(3);
      checkOutput($sformatf("pulse_hold%0d", i), 32'(led8), 32'(expQ[i]));
    end
    pause = 1'b0;
    expQ  = '{16'h70, 16'hE0, 16'hC1, 16'h83, 16'h07};
    tickQ = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    stepCheck("resume", 2);

    pat_sel = 3'd1;
    expQ  = '{16'h03, 16'h06, 16'h0C, 16'h18, 16'h30};
    tickQ = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    stepCheck("walk", 2);
    pat_sel = 3'd3;
    expQ  = '{16'hFF, 16'h00, 16'hFF};
    tickQ = '{1'b1, 1'b0, 1'b1};
    stepCheck("blink", 2);

    pat_sel = 3'd6;
    expQ  = '{16'hE1, 16'hC3, 16'h87};
    tickQ = '{1'b1, 1'b0, 1'b0};
    stepCheck("sparkle", 2);
    rst_n = 1'b0;
    clockCycles(1);
    checkOutput("sparkle_rst_led", 32'(led8), 32'h0);
    checkOutput("sparkle_rst_tick", 32'(tick8), 32'h0);
    rst_n = 1'b1;
    expQ  = '{16'hE1, 16'hC3, 16'h87, 16'h0F};
    tickQ = '{1'b1, 1'b0, 1'b0, 1'b0};
    stepCheck("sparkle_again", 2);

    use12 = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0);
    clockCycles(1);
    checkOutput("rst12_led", 32'(led12), 32'h0);
    rst_n = 1'b1;
    expQ  = '{16'h801, 16'h402, 16'h204, 16'h108, 16'h090, 16'h060, 16'h090, 16'h108, 16'h204, 16'h402};
    tickQ = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    stepCheck("knight12", 2);
    ena = 1'b0;
    clockCycles(10);
    checkOutput("freeze12_led", 32'(led12), 32'h402);
    checkOutput("freeze12_tick", 32'(tick12), 32'h0);
    ena   = 1'b1;
    expQ  = '{16'h801, 16'h402};
    tickQ = '{1'b1, 1'b0};
    stepCheck("thaw12", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
